// File: rtl/prog_counter.sv
`default_nettype none
//============================================================================
// Module   : prog_counter
// Purpose  : Synchronous 6502 program counter (PCL/PCH). Each half either
//            holds or loads from its address bus. The combined value is then
//            optionally incremented. The result is driven onto DB/ADL/ADH
//            through AND-gated, OR-mergeable bus drivers.
// Options  : PC_SPLIT_CARRY_EN - NMOS-accurate split increment. The carry
//            out of PCL is registered in PC_CARRY and is added into PCH on
//            the following clock. PAGE_CROSS exposes the pending carry.
// Revision : 1.0 - initial release
//============================================================================
module prog_counter #(
  parameter int                    HALF_W       = 8,
  parameter logic [2*HALF_W-1:0]   RESET_VECTOR = 16'hFFFC
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  PCL_LOAD_ADL,
  input  logic                  PCH_LOAD_ADH,
  input  logic                  INC,
  input  logic [HALF_W-1:0]     ADL_IN,
  input  logic [HALF_W-1:0]     ADH_IN,
  input  logic                  PCL_DB_EN,
  input  logic                  PCH_DB_EN,
  input  logic                  PCL_ADL_EN,
  input  logic                  PCH_ADH_EN,
  output logic [HALF_W-1:0]     DB_OUT,
  output logic [HALF_W-1:0]     ADL_OUT,
  output logic [HALF_W-1:0]     ADH_OUT,
`ifdef PC_SPLIT_CARRY_EN
  output logic                  PAGE_CROSS,
`endif
  output logic [2*HALF_W-1:0]   PC_OUT
);

  localparam int                  c_PC_W   = 2 * HALF_W;
  localparam logic [HALF_W-1:0]   c_ZERO_H = '0;

  // Architectural state and next-state values
  logic [HALF_W-1:0] pcl_q, pcl_d;
  logic [HALF_W-1:0] pch_q, pch_d;

  // Source-selected halves (hold or bus load)
  logic [HALF_W-1:0] w_pcls;
  logic [HALF_W-1:0] w_pchs;

  assign w_pcls = PCL_LOAD_ADL ? ADL_IN : pcl_q;
  assign w_pchs = PCH_LOAD_ADH ? ADH_IN : pch_q;

`ifdef PC_SPLIT_CARRY_EN
  // Split increment: the carry out of PCL is held for one clock
  logic              carry_q, carry_d;
  logic [HALF_W:0]   w_lo_sum;

  // Low half increments now; the high half absorbs last cycle's carry unless it is loaded
  always_comb begin
    w_lo_sum = {1'b0, w_pcls} + {{HALF_W{1'b0}}, INC};
    pcl_d    = w_lo_sum[HALF_W-1:0];
    carry_d  = w_lo_sum[HALF_W];
    if (PCH_LOAD_ADH) begin
      // A load in the consume cycle wins and the pending carry is dropped
      pch_d = ADH_IN;
    end else begin
      pch_d = pch_q + {{(HALF_W-1){1'b0}}, carry_q};
    end
  end

  // Register update; reset discards any pending carry
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pcl_q   <= RESET_VECTOR[HALF_W-1:0];
      pch_q   <= RESET_VECTOR[c_PC_W-1:HALF_W];
      carry_q <= 1'b0;
    end else begin
      pcl_q   <= pcl_d;
      pch_q   <= pch_d;
      carry_q <= carry_d;
    end
  end

  assign PAGE_CROSS = carry_q;
`else
  // Full-width increment: the PCL carry ripples into PCH in the same cycle
  logic [c_PC_W-1:0] w_full_sum;

  // Combined next PC is the selected pair plus INC, modulo 2^(2*HALF_W)
  always_comb begin
    w_full_sum = {w_pchs, w_pcls} + {{(c_PC_W-1){1'b0}}, INC};
    pcl_d      = w_full_sum[HALF_W-1:0];
    pch_d      = w_full_sum[c_PC_W-1:HALF_W];
  end

  // Register update; reset overrides any load or increment in the same cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pcl_q <= RESET_VECTOR[HALF_W-1:0];
      pch_q <= RESET_VECTOR[c_PC_W-1:HALF_W];
    end else begin
      pcl_q <= pcl_d;
      pch_q <= pch_d;
    end
  end
`endif

  // Bus drivers: a disabled driver outputs 0 so the top level can OR-merge
  // them. Both DB enables together is a protocol error, but the output is
  // still the defined OR.
  always_comb begin
    ADL_OUT = PCL_ADL_EN ? pcl_q : c_ZERO_H;
    ADH_OUT = PCH_ADH_EN ? pch_q : c_ZERO_H;
    DB_OUT  = (PCL_DB_EN ? pcl_q : c_ZERO_H) | (PCH_DB_EN ? pch_q : c_ZERO_H);
  end

  assign PC_OUT = {pch_q, pcl_q};

endmodule
`default_nettype wire
